// File: rtl/display_scan_demux.sv
// Time-multiplexed 7-segment scan driver: one digit per slot, round-robin,
// with a short all-dark blanking window at each slot start to stop ghosting.
module display_scan_demux #(
    parameter int NUM_DIGITS   = 6,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits_bcd,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    output logic [NUM_DIGITS-1:0]   an_n,
    output logic [6:0]              seg_n,
    output logic                    dp_n,
    output logic                    frame_start
);

    localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = NUM_DIGITS'(1);

    typedef enum logic {BLANK, DRIVE} state_t;

    function automatic logic [6:0] decode(input logic [3:0] d);
        case (d)
            4'd0:    decode = 7'h40;
            4'd1:    decode = 7'h79;
            4'd2:    decode = 7'h24;
            4'd3:    decode = 7'h30;
            4'd4:    decode = 7'h19;
            4'd5:    decode = 7'h12;
            4'd6:    decode = 7'h02;
            4'd7:    decode = 7'h78;
            4'd8:    decode = 7'h00;
            4'd9:    decode = 7'h10;
            default: decode = 7'h7F;
        endcase
    endfunction

    state_t        state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [3:0]    cap_digit;
    logic          cap_dp;
    logic          wrapped;   // set once a full frame has completed since reset

    logic          cnt_last;
    logic [CW-1:0] cnt_nxt;
    logic [IW-1:0] idx_nxt;

    assign cnt_last = (cnt == CNT_LAST);
    assign cnt_nxt  = cnt_last ? '0 : cnt + 1'b1;
    assign idx_nxt  = (idx == IDX_LAST) ? '0 : idx + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= BLANK;
            cnt         <= '0;
            idx         <= '0;
            cap_digit   <= 4'hF;
            cap_dp      <= 1'b0;
            wrapped     <= 1'b0;
            an_n        <= '1;
            seg_n       <= 7'h7F;
            dp_n        <= 1'b1;
            frame_start <= 1'b0;
        end else if (!en) begin
            // Dark display; scan position and captured digit are frozen.
            an_n        <= '1;
            seg_n       <= 7'h7F;
            dp_n        <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            an_n        <= (state == DRIVE) ? ~(ONE_HOT0 << idx) : '1;
            seg_n       <= decode(cap_digit);
            dp_n        <= ~cap_dp;
            frame_start <= wrapped && (cnt == '0) && (idx == '0);
            cnt         <= cnt_nxt;
            state       <= (cnt_nxt < BLANK_END) ? BLANK : DRIVE;
            if (cnt_last) begin
                idx       <= idx_nxt;
                cap_digit <= digits_bcd[{idx_nxt, 2'b00} +: 4];
                cap_dp    <= dp_mask[idx_nxt];
                if (idx == IDX_LAST)
                    wrapped <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_display_scan_demux.sv
// Bench for display_scan_demux: directed literal checks plus randomized en/data/reset
// traffic compared every cycle against a model driven by a count of enabled cycles.
module tb_display_scan_demux;

    localparam int N = 6;
    localparam int P = 4;
    localparam int B = 1;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           en;
    logic [4*N-1:0] digits_bcd;
    logic [N-1:0]   dp_mask;
    logic [N-1:0]   an_n;
    logic [6:0]     seg_n;
    logic           dp_n;
    logic           frame_start;

    display_scan_demux #(.NUM_DIGITS(N), .PRESCALE(P), .BLANK_CYCLES(B)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .digits_bcd(digits_bcd), .dp_mask(dp_mask),
        .an_n(an_n), .seg_n(seg_n), .dp_n(dp_n), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    // Model: n = enabled cycles since reset; slot = n/P, cnt = n%P, digit = slot%N.
    int         n = 0;
    logic [3:0] m_cap = 4'hF;
    logic       m_dp = 1'b0;
    logic [N-1:0] e_an = '1;
    logic [6:0] e_seg = 7'h7F;
    logic       e_dp = 1'b1;
    logic       e_fs = 1'b0;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] tbl [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                  7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
        return (d < 10) ? tbl[d] : 7'h7F;
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            n = 0; m_cap = 4'hF; m_dp = 1'b0;
            e_an = '1; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
        end else if (!en) begin
            e_an = '1; e_seg = 7'h7F; e_dp = 1'b1; e_fs = 1'b0;
        end else begin
            int di, ni;
            di    = (n / P) % N;
            e_an  = ((n % P) < B) ? '1 : ~(N'(1) << di);
            e_seg = seg_of(m_cap);
            e_dp  = ~m_dp;
            e_fs  = (n > 0) && (n % (P * N) == 0);
            if (n % P == P - 1) begin
                ni    = (n / P + 1) % N;
                m_cap = digits_bcd[ni*4 +: 4];
                m_dp  = dp_mask[ni];
            end
            n = n + 1;
        end
    end

    always @(negedge clk) begin
        vecs++;
        if ({an_n, seg_n, dp_n, frame_start} !== {e_an, e_seg, e_dp, e_fs}) begin
            errs++;
            $display("FAIL model t=%0t: an_n=%h seg_n=%h dp_n=%b fs=%b, expected an_n=%h seg_n=%h dp_n=%b fs=%b",
                     $time, an_n, seg_n, dp_n, frame_start, e_an, e_seg, e_dp, e_fs);
        end
        vecs++;
        if ($countones(~an_n) > 1) begin
            errs++;
            $display("FAIL onehot t=%0t: an_n=%h, required at most one low bit", $time, an_n);
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step(input int k);
        repeat (k) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; digits_bcd = '0; dp_mask = '0;
        step(3); #1;
        rst_n = 1'b1;
        // Released with en=0: dark, no frame pulse.
        step(20);
        chk("idle_an", 32'(an_n), 32'h3F);
        chk("idle_seg", 32'(seg_n), 32'h7F);
        chk("idle_fs", 32'(frame_start), 32'h0);
        #1;
        digits_bcd = 24'h123456; en = 1'b1;
        step(1);
        chk("n0_an", 32'(an_n), 32'h3F);
        chk("n0_seg", 32'(seg_n), 32'h7F);
        step(1);
        chk("n1_an", 32'(an_n), 32'h3E);
        step(3);
        chk("n4_an", 32'(an_n), 32'h3F);
        chk("n4_seg", 32'(seg_n), 32'h12);
        step(1);
        chk("n5_an", 32'(an_n), 32'h3D);
        step(19);
        chk("frame1_fs", 32'(frame_start), 32'h1);
        chk("frame1_seg", 32'(seg_n), 32'h02);
        #1;
        digits_bcd = 24'h12345C; dp_mask = 6'b000001;
        step(24);
        chk("frame2_fs", 32'(frame_start), 32'h1);
        chk("digC_seg", 32'(seg_n), 32'h7F);
        chk("digC_dp", 32'(dp_n), 32'h0);
        step(1);
        chk("digC_an", 32'(an_n), 32'h3E);
        // Freeze at idx 3, cnt 2.
        step(12); #1;
        en = 1'b0;
        step(10);
        chk("frozen_an", 32'(an_n), 32'h3F);
        chk("frozen_seg", 32'(seg_n), 32'h7F);
        #1;
        en = 1'b1;
        step(1);
        chk("resume_an", 32'(an_n), 32'h37);
        chk("resume_seg", 32'(seg_n), 32'h30);
        step(1);
        chk("resume_an2", 32'(an_n), 32'h37);
        step(1);
        chk("next_slot_an", 32'(an_n), 32'h3F);
        chk("next_slot_seg", 32'(seg_n), 32'h24);
        // Mid-slot change during idx 2 of the next frame.
        step(16); #1;
        digits_bcd = 24'h000000;
        step(1);
        chk("midslot_seg", 32'(seg_n), 32'h19);
        step(23);
        chk("newval_seg", 32'(seg_n), 32'h40);
        step(1);
        chk("newval_an", 32'(an_n), 32'h3B);
        // Reset mid-DRIVE of idx 4.
        step(9);
        chk("idx4_an", 32'(an_n), 32'h2F);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_an", 32'(an_n), 32'h3F);
        chk("async_seg", 32'(seg_n), 32'h7F);
        step(2); #1;
        rst_n = 1'b1;
        step(1);
        chk("rst_blank_an", 32'(an_n), 32'h3F);
        step(1);
        chk("rst_drive_an", 32'(an_n), 32'h3E);
        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            step(1); #1;
            rst_n = ($urandom_range(0, 199) != 0);
            en = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 9) == 0) digits_bcd = 24'($urandom);
            if ($urandom_range(0, 9) == 0) dp_mask = 6'($urandom);
        end
        step(2);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
